// File: rtl/prod_acc.sv
// Saturating block accumulator: sums N accepted products, then holds the result until taken.
// Optional build macro PROD_ACC_CNT_EN adds the blk_cnt released-block counter output.
module prod_acc #(
    parameter int PW = 4,
    parameter int AW = 8,
    parameter int N  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [PW-1:0] prod_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] sum,
    output logic          sum_valid,
    input  logic          sum_ready,
    output logic          ovf
`ifdef PROD_ACC_CNT_EN
    ,
    output logic [7:0]    blk_cnt
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [AW-1:0]  acc_r, acc_nxt_s;
    logic [CW-1:0]  cnt_r, cnt_nxt_s;
    logic           ovf_r, ovf_nxt_s;
    logic [AW:0]    add_s;

    // Zero-extended add; the MSB of the result flags saturation.
    function automatic logic [AW:0] sat_add(input logic [AW-1:0] a, input logic [PW-1:0] b);
        logic [AW:0] raw;
        raw = {1'b0, a} + {{(AW + 1 - PW){1'b0}}, b};
        if (raw[AW]) begin
            sat_add = {1'b1, {AW{1'b1}}};
        end else begin
            sat_add = raw;
        end
    endfunction

    assign in_ready  = (state_r == ACC);
    assign sum_valid = (state_r == HOLD);
    assign sum       = acc_r;
    assign ovf       = ovf_r;

    // State, accumulator, count and overflow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ACC;
            acc_r   <= {AW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Next-state logic: clr outranks accept and release.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        ovf_nxt_s   = ovf_r;
        add_s       = sat_add(acc_r, prod_in);
        if (clr) begin
            state_nxt_s = ACC;
            acc_nxt_s   = {AW{1'b0}};
            cnt_nxt_s   = {CW{1'b0}};
            ovf_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ACC: begin
                    if (in_valid) begin
                        acc_nxt_s = add_s[AW-1:0];
                        ovf_nxt_s = ovf_r | add_s[AW];
                        if (cnt_r == CNT_LAST) begin
                            cnt_nxt_s   = {CW{1'b0}};
                            state_nxt_s = HOLD;
                        end else begin
                            cnt_nxt_s = cnt_r + CW'(1);
                        end
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        state_nxt_s = ACC;
                        acc_nxt_s   = {AW{1'b0}};
                        ovf_nxt_s   = 1'b0;
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                end
                default: begin
                    state_nxt_s = ACC;
                    acc_nxt_s   = {AW{1'b0}};
                    cnt_nxt_s   = {CW{1'b0}};
                    ovf_nxt_s   = 1'b0;
                end
            endcase
        end
    end

`ifdef PROD_ACC_CNT_EN
    logic       release_s;
    logic [7:0] blk_cnt_r;

    assign release_s = (state_r == HOLD) && sum_ready && !clr;
    assign blk_cnt   = blk_cnt_r;

    // Released-block counter; wraps naturally and ignores clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_cnt_r <= 8'd0;
        end else if (release_s) begin
            blk_cnt_r <= blk_cnt_r + 8'd1;
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_prod_acc.sv
// Directed bench for prod_acc: default, AW=5 and N=1 instances share one stimulus bus.
module tb_prod_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [3:0] prod_in;
    logic       in_valid;
    logic       sum_ready;

    logic       rdy0, val0, ovf0;
    logic [7:0] sum0;
    logic       rdy5, val5, ovf5;
    logic [4:0] sum5;
    logic       rdy1, val1, ovf1;
    logic [7:0] sum1;
`ifdef PROD_ACC_CNT_EN
    logic [7:0] bc0, bc5, bc1;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    prod_acc #(.PW(4), .AW(8), .N(4)) d0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .prod_in(prod_in), .in_valid(in_valid),
        .in_ready(rdy0), .sum(sum0), .sum_valid(val0), .sum_ready(sum_ready), .ovf(ovf0)
`ifdef PROD_ACC_CNT_EN
        , .blk_cnt(bc0)
`endif
    );

    prod_acc #(.PW(4), .AW(5), .N(4)) d5 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .prod_in(prod_in), .in_valid(in_valid),
        .in_ready(rdy5), .sum(sum5), .sum_valid(val5), .sum_ready(sum_ready), .ovf(ovf5)
`ifdef PROD_ACC_CNT_EN
        , .blk_cnt(bc5)
`endif
    );

    prod_acc #(.PW(4), .AW(8), .N(1)) d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .prod_in(prod_in), .in_valid(in_valid),
        .in_ready(rdy1), .sum(sum1), .sum_valid(val1), .sum_ready(sum_ready), .ovf(ovf1)
`ifdef PROD_ACC_CNT_EN
        , .blk_cnt(bc1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] d);
        in_valid = v;
        prod_in  = d;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; sum_ready = 1'b0; prod_in = 4'd0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; sum_ready = 1'b0;
        in_valid = 1'b1; prod_in = 4'd9;
        // Reset wins over an active in_valid
        tick(); tick();
        check("rst_sum", sum0, 8'd0);
        check("rst_valid", val0, 1'b0);
        check("rst_ready", rdy0, 1'b1);
        check("rst_ovf", ovf0, 1'b0);
        rst_n = 1'b1; in_valid = 1'b0;

        // Basic block 9+4+1+6
        drive(1'b1, 4'd9);
        check("blk_partial", sum0, 8'd9);
        check("blk_partial_valid", val0, 1'b0);
        drive(1'b1, 4'd4);
        drive(1'b1, 4'd1);
        drive(1'b1, 4'd6);
        check("blk_sum", sum0, 8'd20);
        check("blk_valid", val0, 1'b1);
        check("blk_ovf", ovf0, 1'b0);
        check("blk_ready", rdy0, 1'b0);

        // Backpressure holds the result and ignores input
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd3);
            check("bp_sum", sum0, 8'd20);
            check("bp_valid", val0, 1'b1);
        end
        sum_ready = 1'b1;
        drive(1'b1, 4'd3);
        sum_ready = 1'b0;
        check("rel_valid", val0, 1'b0);
        check("rel_sum", sum0, 8'd0);
        check("rel_ready", rdy0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'd1);
        check("bp_next_sum", sum0, 8'd4);
        check("bp_next_valid", val0, 1'b1);

        // Saturation on AW=5
        do_reset();
        drive(1'b1, 4'd9);
        drive(1'b1, 4'd9);
        drive(1'b1, 4'd9);
        check("sat_pre_ovf", ovf5, 1'b0);
        drive(1'b1, 4'd9);
        check("sat_sum", sum5, 5'd31);
        check("sat_ovf", ovf5, 1'b1);
        check("sat_valid", val5, 1'b1);
        check("wide_sum", sum0, 8'd36);
        check("wide_ovf", ovf0, 1'b0);
        sum_ready = 1'b1;
        drive(1'b0, 4'd0);
        sum_ready = 1'b0;
        check("sat_rel_ovf", ovf5, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'd2);
        check("sat_next_sum", sum5, 5'd8);
        check("sat_next_ovf", ovf5, 1'b0);

        // clr drops a partial block and the simultaneous sample
        do_reset();
        drive(1'b1, 4'd5);
        drive(1'b1, 4'd5);
        clr = 1'b1;
        drive(1'b1, 4'd7);
        clr = 1'b0;
        check("clr_sum", sum0, 8'd0);
        check("clr_ready", rdy0, 1'b1);
        drive(1'b1, 4'd1);
        drive(1'b1, 4'd2);
        drive(1'b1, 4'd3);
        check("clr_cnt_valid", val0, 1'b0);
        drive(1'b1, 4'd4);
        check("clr_next_sum", sum0, 8'd10);
        check("clr_next_valid", val0, 1'b1);
        clr = 1'b1;
        drive(1'b0, 4'd0);
        clr = 1'b0;
        check("clr_hold_valid", val0, 1'b0);
        check("clr_hold_sum", sum0, 8'd0);

        // Gaps do not advance the count
        do_reset();
        drive(1'b1, 4'd2);
        drive(1'b0, 4'd9);
        drive(1'b0, 4'd9);
        drive(1'b1, 4'd3);
        drive(1'b0, 4'd9);
        drive(1'b1, 4'd4);
        check("gap_partial", sum0, 8'd9);
        check("gap_partial_valid", val0, 1'b0);
        drive(1'b1, 4'd5);
        check("gap_sum", sum0, 8'd14);
        check("gap_valid", val0, 1'b1);

        // N=1: every sample is a block, one idle cycle per release
        do_reset();
        sum_ready = 1'b1;
        drive(1'b1, 4'd7);
        check("n1_sum_a", sum1, 8'd7);
        check("n1_valid_a", val1, 1'b1);
        check("n1_ready_a", rdy1, 1'b0);
        drive(1'b1, 4'd8);
        check("n1_rel_valid", val1, 1'b0);
        check("n1_rel_ready", rdy1, 1'b1);
        check("n1_rel_sum", sum1, 8'd0);
        drive(1'b1, 4'd8);
        check("n1_sum_b", sum1, 8'd8);
        check("n1_valid_b", val1, 1'b1);
        check("n1_ovf", ovf1, 1'b0);
        drive(1'b0, 4'd0);
        sum_ready = 1'b0;
`ifdef PROD_ACC_CNT_EN
        check("blk_cnt_n1", bc1, 8'd2);
        clr = 1'b1;
        drive(1'b0, 4'd0);
        clr = 1'b0;
        check("blk_cnt_clr", bc1, 8'd2);
`endif
        check("n1_idle_ready", rdy1, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
